corr_lut_gen: RTL and testbench

- Parametrised, runtime-programmable generator and lookup store for modular correction constants used in the multiplier reduction path.
- Generates an arithmetic-progression table: entry[0]=0, entry[1]=BASE, entry[k]=entry[k-1]∓STEP mod 2^W.
- Table is built in hardware from a single configuration beat, then serves registered index lookups.
- Replaces fixed hard-coded correction tables; allows width, depth and modulus constants to change without RTL edits.

---
 rtl/corr_lut_gen.sv | 137 +++++++++++++
 tb/tb_corr_lut_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_lut_gen.sv
// Builds an arithmetic-progression correction table from one config beat, then serves lookups.
// Lookup latency 1 cycle; no output backpressure; config is refused (cfg_ready=0) while the table builds.
module corr_lut_gen #(
    parameter int W  = 40,
    parameter int MB = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [W-1:0]  cfg_base,
    input  logic [W-1:0]  cfg_step,
    input  logic          cfg_sub,
    output logic          table_valid,
    input  logic          lk_valid,
    input  logic [MB-1:0] lk_idx,
    output logic          out_valid,
    output logic [W-1:0]  corr_out,
    output logic          lk_miss
);

    localparam int DEPTH = 1 << MB;
    localparam logic [MB-1:0] K_FIRST = MB'(2);
    localparam logic [MB-1:0] K_LAST  = MB'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        READY = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   step_q, step_d;
    logic           sub_q, sub_d;
    logic [MB-1:0]  k_q, k_d;
    logic           tv_q, tv_d;
    logic           ov_q, ov_d;
    logic [W-1:0]   corr_q, corr_d;
    logic           miss_q, miss_d;
    logic [W-1:0]   mem_q [DEPTH];

    logic           cfg_acc;
    logic [W-1:0]   nxt;

    always_comb begin
        cfg_ready = (state_q != BUILD);
        cfg_acc   = cfg_valid && cfg_ready;
        nxt       = sub_q ? (acc_q - step_q) : (acc_q + step_q);

        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        sub_d   = sub_q;
        k_d     = k_q;
        tv_d    = tv_q;
        ov_d    = 1'b0;
        corr_d  = corr_q;
        miss_d  = 1'b0;

        // Reads see the table as it stood before this edge, so a lookup that
        // coincides with a reconfiguration is served from the old contents.
        if (lk_valid) begin
            if (tv_q) begin
                ov_d   = 1'b1;
                corr_d = mem_q[lk_idx];
            end else begin
                miss_d = 1'b1;
            end
        end

        case (state_q)
            IDLE, READY: begin
                if (cfg_acc) begin
                    acc_d   = cfg_base;
                    step_d  = cfg_step;
                    sub_d   = cfg_sub;
                    k_d     = K_FIRST;
                    tv_d    = 1'b0;
                    state_d = BUILD;
                end
            end
            BUILD: begin
                acc_d = nxt;
                k_d   = k_q + MB'(1);
                if (k_q == K_LAST) begin
                    tv_d    = 1'b1;
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            sub_q   <= 1'b0;
            k_q     <= '0;
            tv_q    <= 1'b0;
            ov_q    <= 1'b0;
            corr_q  <= '0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            sub_q   <= sub_d;
            k_q     <= k_d;
            tv_q    <= tv_d;
            ov_q    <= ov_d;
            corr_q  <= corr_d;
            miss_q  <= miss_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (cfg_acc) begin
            mem_q[0] <= '0;
            mem_q[1] <= cfg_base;
        end else if (state_q == BUILD) begin
            mem_q[k_q] <= nxt;
        end
    end

    assign table_valid = tv_q;
    assign out_valid   = ov_q;
    assign corr_out    = corr_q;
    assign lk_miss     = miss_q;

endmodule

// File: tb/tb_corr_lut_gen.sv
// Randomized self-checking bench for corr_lut_gen against a closed-form table model.
module tb_corr_lut_gen;

    localparam int W     = 40;
    localparam int MB    = 3;
    localparam int DEPTH = 1 << MB;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [W-1:0]  cfg_base;
    logic [W-1:0]  cfg_step;
    logic          cfg_sub;
    logic          table_valid;
    logic          lk_valid;
    logic [MB-1:0] lk_idx;
    logic          out_valid;
    logic [W-1:0]  corr_out;
    logic          lk_miss;

    corr_lut_gen #(.W(W), .MB(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_base    (cfg_base),
        .cfg_step    (cfg_step),
        .cfg_sub     (cfg_sub),
        .table_valid (table_valid),
        .lk_valid    (lk_valid),
        .lk_idx      (lk_idx),
        .out_valid   (out_valid),
        .corr_out    (corr_out),
        .lk_miss     (lk_miss)
    );

    always #5 clk = ~clk;

    int           n_chk = 0;
    int           n_err = 0;
    logic [W-1:0] mdl [DEPTH];
    logic [W-1:0] exp_last;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // entry[k] = base -/+ (k-1)*step mod 2^W, entry[0] = 0
    task automatic build_model(input logic [W-1:0] base, input logic [W-1:0] step, input logic sub);
        logic [W-1:0] km1;
        logic [W-1:0] off;
        mdl[0] = '0;
        for (int k = 1; k < DEPTH; k++) begin
            km1    = W'(k - 1);
            off    = step * km1;
            mdl[k] = sub ? (base - off) : (base + off);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [W-1:0] base, input logic [W-1:0] step, input logic sub);
        cfg_valid = 1'b1;
        cfg_base  = base;
        cfg_step  = step;
        cfg_sub   = sub;
        tick();
        cfg_valid = 1'b0;
        build_model(base, step, sub);
        chk("tv_after_accept", table_valid, 0);
        chk("rdy_after_accept", cfg_ready, 0);
    endtask

    task automatic wait_build(input bit noise);
        int n = 0;
        while (!table_valid && n < 20) begin
            chk("rdy_in_build", cfg_ready, 0);
            if (noise) begin
                cfg_valid = 1'($urandom_range(0, 1));
                cfg_base  = W'({$urandom, $urandom});
                cfg_step  = W'({$urandom, $urandom});
                cfg_sub   = 1'($urandom_range(0, 1));
            end
            tick();
            n++;
        end
        cfg_valid = 1'b0;
        chk("build_len", 64'(n), 64'(DEPTH - 2));
        chk("rdy_in_ready", cfg_ready, 1);
    endtask

    task automatic lookup_all();
        for (int i = 0; i < DEPTH; i++) begin
            lk_valid = 1'b1;
            lk_idx   = MB'(i);
            tick();
            chk("lk_ov", out_valid, 1);
            chk("lk_val", corr_out, mdl[i]);
            chk("lk_nomiss", lk_miss, 0);
            exp_last = mdl[i];
        end
        lk_valid = 1'b0;
    endtask

    logic [W-1:0] spec_tab [DEPTH];
    logic [W-1:0] old7;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        spec_tab[0] = 40'h0;
        spec_tab[1] = 40'h8000000000;
        spec_tab[2] = 40'h7a4039a011;
        spec_tab[3] = 40'h7480734022;
        spec_tab[4] = 40'h6ec0ace033;
        spec_tab[5] = 40'h6900e68044;
        spec_tab[6] = 40'h6341202055;
        spec_tab[7] = 40'h5d8159c066;

        rst = 1'b1; cfg_valid = 1'b0; cfg_base = '0; cfg_step = '0; cfg_sub = 1'b0;
        lk_valid = 1'b0; lk_idx = '0; exp_last = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_table_valid", table_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_corr_out", corr_out, 0);
        chk("rst_lk_miss", lk_miss, 0);

        // lookup before any table exists
        lk_valid = 1'b1; lk_idx = 3'd3;
        tick();
        lk_valid = 1'b0;
        chk("miss_pulse", lk_miss, 1);
        chk("miss_ov", out_valid, 0);
        chk("miss_corr", corr_out, 0);
        chk("miss_rdy", cfg_ready, 1);
        tick();
        chk("miss_one_cycle", lk_miss, 0);

        // reference table from the documented example
        do_cfg(40'h8000000000, 40'h05bfc65fef, 1'b1);
        wait_build(1'b0);
        for (int i = 0; i < DEPTH; i++) chk("spec_model", mdl[i], spec_tab[i]);
        lookup_all();
        tick();
        chk("idle_ov", out_valid, 0);
        chk("idle_hold", corr_out, exp_last);

        // reconfigure with a same-edge lookup: old table answers
        old7 = mdl[7];
        cfg_valid = 1'b1; cfg_base = 40'h10; cfg_step = 40'h1; cfg_sub = 1'b1;
        lk_valid = 1'b1; lk_idx = 3'd7;
        tick();
        cfg_valid = 1'b0; lk_valid = 1'b0;
        build_model(40'h10, 40'h1, 1'b1);
        chk("rbw_ov", out_valid, 1);
        chk("rbw_val", corr_out, old7);
        chk("rbw_tv", table_valid, 0);
        exp_last = old7;
        wait_build(1'b1);
        lookup_all();

        // additive wrap-around
        do_cfg(40'hFFFFFFFFF0, 40'h20, 1'b0);
        wait_build(1'b0);
        chk("wrap_m2", mdl[2], 40'h10);
        chk("wrap_m7", mdl[7], 40'hB0);
        lookup_all();

        // reset in the third build cycle
        do_cfg(40'h123456789A, 40'h1111, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_last = '0;
        chk("mid_rst_tv", table_valid, 0);
        chk("mid_rst_rdy", cfg_ready, 1);
        chk("mid_rst_corr", corr_out, 0);
        tick();
        chk("mid_rst_stays_idle", table_valid, 0);
        lk_valid = 1'b1; lk_idx = 3'd1;
        tick();
        lk_valid = 1'b0;
        chk("mid_rst_miss", lk_miss, 1);
        chk("mid_rst_ov", out_valid, 0);
        do_cfg(40'h0A0A0A0A0A, 40'h0101010101, 1'b1);
        wait_build(1'b0);
        lookup_all();

        // continuous stream 0..7,0
        for (int i = 0; i <= DEPTH; i++) begin
            lk_valid = 1'b1;
            lk_idx   = MB'(i % DEPTH);
            tick();
            chk("stream_ov", out_valid, 1);
            chk("stream_val", corr_out, mdl[i % DEPTH]);
            exp_last = mdl[i % DEPTH];
        end
        lk_valid = 1'b0;
        tick();
        chk("stream_end_ov", out_valid, 0);
        chk("stream_end_hold", corr_out, exp_last);

        // random tables with random sparse lookups
        for (int r = 0; r < 6; r++) begin
            logic [W-1:0] b, s;
            logic         sb;
            b  = W'({$urandom, $urandom});
            s  = W'({$urandom, $urandom});
            sb = 1'($urandom_range(0, 1));
            do_cfg(b, s, sb);
            wait_build(r[0]);
            for (int c = 0; c < 40; c++) begin
                logic          v;
                logic [MB-1:0] ix;
                v  = ($urandom_range(0, 3) != 0);
                ix = MB'($urandom_range(0, DEPTH - 1));
                lk_valid = v;
                lk_idx   = ix;
                tick();
                if (v) exp_last = mdl[ix];
                chk("rnd_ov", out_valid, 64'(v));
                chk("rnd_val", corr_out, exp_last);
                chk("rnd_miss", lk_miss, 0);
            end
            lk_valid = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
